// File: rtl/result_drain_if.sv
// Result stream bus from result_drain: element data with row/column/last tags.
// With DRAIN_PARITY_EN defined, an even-parity bit travels alongside m_data.
interface result_drain_if #(
    parameter int unsigned N        = 4,
    parameter int unsigned OUTWIDTH = 8
);
    localparam int unsigned RCW = (N > 1) ? $clog2(N) : 1;

    logic                m_valid;
    logic                m_ready;
    logic [OUTWIDTH-1:0] m_data;
    logic [RCW-1:0]      m_row;
    logic [RCW-1:0]      m_col;
    logic                m_last;
`ifdef DRAIN_PARITY_EN
    logic                m_parity;
`endif

    modport master (
        output m_valid, m_data, m_row, m_col, m_last,
`ifdef DRAIN_PARITY_EN
        output m_parity,
`endif
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_row, m_col, m_last,
`ifdef DRAIN_PARITY_EN
        input  m_parity,
`endif
        output m_ready
    );
endinterface

// File: rtl/result_drain.sv
// result_drain: snapshots the N x N PE results on start, pulses clear_array, then streams
// the snapshot row-major over a valid/ready bus. Optional parity output: DRAIN_PARITY_EN.
module result_drain #(
    parameter int unsigned N        = 4,
    parameter int unsigned BITWIDTH = 4,
    parameter int unsigned OUTWIDTH = 2 * BITWIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N*N*OUTWIDTH-1:0]   results,
    output logic                      clear_array,
    output logic                      busy,
    output logic                      done,
    result_drain_if.master            m
);
    localparam int unsigned NUM  = N * N;
    localparam int unsigned IDXW = $clog2(NUM);
    localparam int unsigned RCW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM - 1);
    localparam logic [IDXW-1:0] N_IDX    = IDXW'(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDXW-1:0]         idx;
    logic [IDXW-1:0]         idx_nxt;
    logic [NUM*OUTWIDTH-1:0] snap;

    logic                    clear_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    valid_q;
    logic [OUTWIDTH-1:0]     data_q;
    logic [RCW-1:0]          row_q;
    logic [RCW-1:0]          col_q;
    logic                    last_q;

    logic                    clear_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;
    logic                    valid_nxt;
    logic [OUTWIDTH-1:0]     data_nxt;
    logic [RCW-1:0]          row_nxt;
    logic [RCW-1:0]          col_nxt;
    logic                    last_nxt;

`ifdef DRAIN_PARITY_EN
    logic                    parity_q;
    logic                    parity_nxt;
`endif

    logic                    xfer_c;
    logic                    capture_c;
    logic [IDXW-1:0]         load_idx_c;
    logic [OUTWIDTH-1:0]     load_data_c;

    assign xfer_c    = valid_q && m.m_ready;
    assign capture_c = (state == IDLE) && start;

    // First STREAM cycle presents the current idx; every later load is the element after it.
    assign load_idx_c  = valid_q ? IDXW'(idx + 1'b1) : idx;
    assign load_data_c = snap[load_idx_c*OUTWIDTH +: OUTWIDTH];

    // State register, element index and snapshot bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            snap  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (capture_c) begin
                snap <= results;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = STREAM;
            STREAM:  if (xfer_c && (idx == LAST_IDX)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and the index
    always_comb begin
        clear_nxt = 1'b0;
        done_nxt  = 1'b0;
        busy_nxt  = (state_nxt != IDLE);
        valid_nxt = 1'b0;
        data_nxt  = data_q;
        row_nxt   = row_q;
        col_nxt   = col_q;
        last_nxt  = last_q;
        idx_nxt   = idx;
`ifdef DRAIN_PARITY_EN
        parity_nxt = parity_q;
`endif
        case (state)
            CLEAR: begin
                clear_nxt = 1'b1;
                idx_nxt   = '0;
            end
            STREAM: begin
                valid_nxt = 1'b1;
                if (!valid_q || (xfer_c && (idx != LAST_IDX))) begin
                    idx_nxt  = load_idx_c;
                    data_nxt = load_data_c;
                    row_nxt  = RCW'(load_idx_c / N_IDX);
                    col_nxt  = RCW'(load_idx_c % N_IDX);
                    last_nxt = (load_idx_c == LAST_IDX);
`ifdef DRAIN_PARITY_EN
                    parity_nxt = ^load_data_c;
`endif
                end else if (xfer_c) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
`ifdef DRAIN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            clear_q <= clear_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            valid_q <= valid_nxt;
            data_q  <= data_nxt;
            row_q   <= row_nxt;
            col_q   <= col_nxt;
            last_q  <= last_nxt;
`ifdef DRAIN_PARITY_EN
            parity_q <= parity_nxt;
`endif
        end
    end

    assign clear_array = clear_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign m.m_valid   = valid_q;
    assign m.m_data    = data_q;
    assign m.m_row     = row_q;
    assign m.m_col     = col_q;
    assign m.m_last    = last_q;
`ifdef DRAIN_PARITY_EN
    assign m.m_parity  = parity_q;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain with N=4, OUTWIDTH=8: capture, clear pulse,
// row-major stream under back-pressure, snapshot isolation, ignored starts, mid-stream reset.
module tb_result_drain;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] results;
    logic         clear_array;
    logic         busy;
    logic         done;
    int           checks = 0;
    int           errors = 0;
    int           clr_cnt = 0;

    result_drain_if #(.N(4), .OUTWIDTH(8)) m ();

    result_drain #(.N(4), .BITWIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .results     (results),
        .clear_array (clear_array),
        .busy        (busy),
        .done        (done),
        .m           (m)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (clear_array === 1'b1) clr_cnt <= clr_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input int k, input logic [7:0] mask);
        return 8'(((k / 4) * 16) + (k % 4)) ^ mask;
    endfunction

    task automatic set_results(input logic [7:0] mask);
        for (int i = 0; i < 16; i++) results[i*8 +: 8] = exp_data(i, mask);
    endtask

    // Drains one stream from the first valid cycle; ready follows pat[c%4].
    task automatic drain(input logic [7:0] mask, input logic [3:0] pat, input int exp_cycles,
                         input int inject_at, input int stop_at);
        int k = 0;
        int c = 0;
        int w = 0;
        while (m.m_valid !== 1'b1 && w < 8) begin
            tick();
            w++;
        end
        check("valid_start", 32'(m.m_valid), 32'd1);
        while (k < 16 && c < 200) begin
            check("valid_held", 32'(m.m_valid), 32'd1);
            check("data", 32'(m.m_data), 32'(exp_data(k, mask)));
            check("row", 32'(m.m_row), 32'(k / 4));
            check("col", 32'(m.m_col), 32'(k % 4));
            check("last", 32'(m.m_last), 32'(k == 15));
`ifdef DRAIN_PARITY_EN
            check("parity", 32'(m.m_parity), 32'(^exp_data(k, mask)));
`endif
            if (k == stop_at) begin
                start = 1'b0;
                return;
            end
            start     = (c == inject_at);
            m.m_ready = pat[c % 4];
            if (m.m_ready) k++;
            tick();
            c++;
        end
        start = 1'b0;
        check("stream_cycles", 32'(c), 32'(exp_cycles));
        check("done_pulse", 32'(done), 32'd1);
        check("valid_after", 32'(m.m_valid), 32'd0);
        check("last_after", 32'(m.m_last), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clear"}, 32'(clear_array), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(m.m_valid), 32'd0);
        check({tag, "_data"}, 32'(m.m_data), 32'd0);
        check({tag, "_row"}, 32'(m.m_row), 32'd0);
        check({tag, "_col"}, 32'(m.m_col), 32'd0);
        check({tag, "_last"}, 32'(m.m_last), 32'd0);
`ifdef DRAIN_PARITY_EN
        check({tag, "_parity"}, 32'(m.m_parity), 32'd0);
`endif
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        m.m_ready = 1'b0;
        set_results(8'h00);
        #1;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Basic stream with ready held high, cycle-exact clear/valid timing
        m.m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t0_busy", 32'(busy), 32'd1);
        check("t0_clear", 32'(clear_array), 32'd0);
        check("t0_valid", 32'(m.m_valid), 32'd0);
        tick();
        check("t1_clear", 32'(clear_array), 32'd1);
        check("t1_valid", 32'(m.m_valid), 32'd0);
        tick();
        check("t2_clear", 32'(clear_array), 32'd0);
        check("t2_valid", 32'(m.m_valid), 32'd1);
        drain(8'h00, 4'b1111, 16, -1, -1);
        tick();
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("clr_cnt1", 32'(clr_cnt), 32'd1);

        // Back-pressure: ready 1,0,0,1 repeating -> 32 valid cycles for 16 transfers
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(8'h00, 4'b1001, 32, -1, -1);
        tick();
        check("bp_busy", 32'(busy), 32'd0);
        check("clr_cnt2", 32'(clr_cnt), 32'd2);

        // Snapshot isolation: inputs go to 0xFF right after capture
        start = 1'b1;
        tick();
        start = 1'b0;
        results = '1;
        drain(8'h00, 4'b1111, 16, -1, -1);
        tick();
        check("clr_cnt3", 32'(clr_cnt), 32'd3);

        // Starts in CLEAR, STREAM and DONE are dropped; inputs change to mask 0x5A meanwhile
        set_results(8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_results(8'h5A);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(8'h00, 4'b1111, 16, 5, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy0", 32'(busy), 32'd0);
        check("ign_clear0", 32'(clear_array), 32'd0);
        tick();
        check("ign_busy1", 32'(busy), 32'd0);
        check("ign_clear1", 32'(clear_array), 32'd0);
        check("ign_valid1", 32'(m.m_valid), 32'd0);
        check("clr_cnt4", 32'(clr_cnt), 32'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(8'h5A, 4'b1111, 16, -1, -1);
        tick();
        check("clr_cnt5", 32'(clr_cnt), 32'd5);

        // Reset while element 7 is presented abandons the stream
        set_results(8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(8'h00, 4'b1111, 16, -1, 7);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        check("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_rel_busy", 32'(busy), 32'd0);
        check("rst_rel_done", 32'(done), 32'd0);
        check("rst_rel_valid", 32'(m.m_valid), 32'd0);
        check("rst_rel_clear", 32'(clear_array), 32'd0);
        check("clr_cnt6", 32'(clr_cnt), 32'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(8'h00, 4'b1111, 16, -1, -1);
        tick();
        check("final_busy", 32'(busy), 32'd0);
        check("clr_cnt7", 32'(clr_cnt), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
